video_timing: RTL



---
 rtl/video_pkg.sv | 47 ++++
 rtl/vid_delay.sv | 49 ++++
 rtl/video_timing.sv | 115 +++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared raster timing constants: standard mode geometries, sync polarities
// and the layout of the raw video-control word carried through the delay line.
package video_pkg;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    localparam int MAX_PIPE = 15;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int   VGA_HACT = 640;
    localparam int   VGA_HFP  = 16;
    localparam int   VGA_HSW  = 96;
    localparam int   VGA_HBP  = 48;
    localparam int   VGA_VACT = 480;
    localparam int   VGA_VFP  = 10;
    localparam int   VGA_VSW  = 2;
    localparam int   VGA_VBP  = 33;
    localparam int   VGA_HTOT = VGA_HACT + VGA_HFP + VGA_HSW + VGA_HBP;
    localparam int   VGA_VTOT = VGA_VACT + VGA_VFP + VGA_VSW + VGA_VBP;
    localparam logic VGA_HPOL = POL_LOW;
    localparam logic VGA_VPOL = POL_LOW;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int   SVGA_HACT = 800;
    localparam int   SVGA_HFP  = 40;
    localparam int   SVGA_HSW  = 128;
    localparam int   SVGA_HBP  = 88;
    localparam int   SVGA_VACT = 600;
    localparam int   SVGA_VFP  = 1;
    localparam int   SVGA_VSW  = 4;
    localparam int   SVGA_VBP  = 23;
    localparam int   SVGA_HTOT = SVGA_HACT + SVGA_HFP + SVGA_HSW + SVGA_HBP;
    localparam int   SVGA_VTOT = SVGA_VACT + SVGA_VFP + SVGA_VSW + SVGA_VBP;
    localparam logic SVGA_HPOL = POL_HIGH;
    localparam logic SVGA_VPOL = POL_HIGH;

    // Sync bits are "asserted" flags here; polarity is applied only at the pins.
    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } raw_t;

    localparam raw_t RAW_IDLE = '{vs: 1'b0, hs: 1'b0, de: 1'b0};

endpackage

// File: rtl/vid_delay.sv
// Enable-gated shift register of DEPTH words with synchronous reset to INIT;
// DEPTH = 0 degenerates to a wire.
module vid_delay #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 0,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_i, en_i};
        assign q_o         = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            // NOTE: defaulting every combinational output first means no path can infer a latch.
            stage_d = stage_q;
            if (en_i) begin
                stage_d[0] = d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                // NOTE: this storage is reset deliberately: a flushed line must present inactive video.
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= INIT;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing.sv
// Parametrised raster timing generator: pixel/line/frame counters, data enable,
// polarity-programmable syncs aligned to a PIPE-deep pixel pipeline, line/frame strobes.
module video_timing
    import video_pkg::*;
#(
    parameter int   HACT = VGA_HACT,
    parameter int   HFP  = VGA_HFP,
    parameter int   HSW  = VGA_HSW,
    parameter int   HBP  = VGA_HBP,
    parameter int   VACT = VGA_VACT,
    parameter int   VFP  = VGA_VFP,
    parameter int   VSW  = VGA_VSW,
    parameter int   VBP  = VGA_VBP,
    parameter logic HPOL = VGA_HPOL,
    parameter logic VPOL = VGA_VPOL,
    parameter int   PIPE = 0,
    parameter int   FW   = 8,
    localparam int  HTOT = HACT + HFP + HSW + HBP,
    localparam int  VTOT = VACT + VFP + VSW + VBP,
    localparam int  HSZ  = $clog2(HTOT),
    localparam int  VSZ  = $clog2(VTOT)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    output logic [HSZ-1:0] hcount_o,
    output logic [VSZ-1:0] vcount_o,
    output logic           de_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           sol_o,
    output logic           sof_o,
    output logic [FW-1:0]  frame_o
);

    if (HACT < 1 || HFP < 1 || HSW < 1 || HBP < 1 ||
        VACT < 1 || VFP < 1 || VSW < 1 || VBP < 1 || FW < 1) begin : g_bad_geometry
        $fatal(1, "video_timing: every geometry field and FW must be at least 1");
    end
    if (PIPE < 0 || PIPE > MAX_PIPE) begin : g_bad_pipe
        $fatal(1, "video_timing: PIPE must lie in 0..15");
    end

    localparam logic [HSZ-1:0] H_LAST = HSZ'(HTOT - 1);
    localparam logic [HSZ-1:0] H_ACT  = HSZ'(HACT);
    localparam logic [HSZ-1:0] HS_BEG = HSZ'(HACT + HFP);
    localparam logic [HSZ-1:0] HS_END = HSZ'(HACT + HFP + HSW);
    localparam logic [VSZ-1:0] V_LAST = VSZ'(VTOT - 1);
    localparam logic [VSZ-1:0] V_ACT  = VSZ'(VACT);
    localparam logic [VSZ-1:0] VS_BEG = VSZ'(VACT + VFP);
    localparam logic [VSZ-1:0] VS_END = VSZ'(VACT + VFP + VSW);

    logic [HSZ-1:0] h_q, h_d;
    logic [VSZ-1:0] v_q, v_d;
    logic [FW-1:0]  frame_q, frame_d;
    raw_t           raw, raw_dly;

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        if (en_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d     = '0;
                    frame_d = frame_q + FW'(1);
                end else begin
                    v_d = v_q + VSZ'(1);
                end
            end else begin
                h_d = h_q + HSZ'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    // vsync is decided by line index alone, so it switches together with h wrapping to 0.
    assign raw.de = (h_q < H_ACT) && (v_q < V_ACT);
    assign raw.hs = (h_q >= HS_BEG) && (h_q < HS_END);
    assign raw.vs = (v_q >= VS_BEG) && (v_q < VS_END);

    vid_delay #(
        .WIDTH ($bits(raw_t)),
        .DEPTH (PIPE),
        .INIT  (RAW_IDLE)
    ) u_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .d_i   (raw),
        .q_o   (raw_dly)
    );

    assign hcount_o = h_q;
    assign vcount_o = v_q;
    assign frame_o  = frame_q;
    assign de_o     = raw_dly.de;
    assign hsync_o  = raw_dly.hs ? HPOL : ~HPOL;
    assign vsync_o  = raw_dly.vs ? VPOL : ~VPOL;
    assign sol_o    = en_i && (h_q == '0);
    assign sof_o    = sol_o && (v_q == '0);

endmodule
